// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and datapath width.
// Imported by alu_64 and by every requester that drives its funct/operand interface.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [2:0] {
    SUM         = 3'd0,
    SHIFT_LEFT  = 3'd1,
    SUB         = 3'd2,
    LOAD        = 3'd3,
    XOR         = 3'd4,
    SHIFT_RIGHT = 3'd5,
    NOT         = 3'd6,
    AND         = 3'd7
  } alu_funct_e;

endpackage

// File: rtl/alu_64.sv
// Combinational 64-bit ALU with a signed-overflow flag for SUM/SUB.
// Zero latency, no handshake: result and overflow follow the inputs in the same cycle.
module alu_64
  import alu_pkg::*;
(
  input  logic [2:0]           funct,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 overflow
);

  logic [ALU_WIDTH-1:0] sum;
  logic [ALU_WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = sum;
    overflow = 1'b0;
    case (alu_funct_e'(funct))
      SUM: begin
        result   = sum;
        overflow = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) && (sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
      end
      SUB: begin
        result   = diff;
        overflow = (a[ALU_WIDTH-1] != b[ALU_WIDTH-1]) && (diff[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
      end
      SHIFT_LEFT:  result = a << b[5:0];
      SHIFT_RIGHT: result = a >> b[5:0];
      LOAD:        result = b;
      XOR:         result = a ^ b;
      NOT:         result = ~a;
      AND:         result = a & b;
    endcase
  end

endmodule

// File: rtl/mul_booth_64.sv
// Radix-2 Booth signed 64x64 multiplier driving an external alu_64; done 65 cycles after accept,
// start ignored while busy (ready=0). Optional high product port under MUL_HIGH_EN.
module mul_booth_64
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
`ifdef MUL_HIGH_EN
  output logic [WIDTH-1:0] product_hi,
`endif
  output logic [2:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  mul_state_e state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic [5:0]       cnt;
  alu_funct_e       funct_sel;
  logic             s;

  // Booth step request; the ALU only sees live operands while running.
  always_comb begin
    funct_sel = SUM;
    alu_a     = '0;
    alu_b     = '0;
    if (state == RUN) begin
      alu_a = acc;
      case ({q[0], q_m1})
        2'b01: alu_b = m;
        2'b10: begin
          funct_sel = SUB;
          alu_b     = m;
        end
        default: alu_b = '0;
      endcase
    end
  end

  assign alu_funct = funct_sel;

  // True sign of the 65-bit sum, so m = -2^63 shifts in the correct bit.
  assign s = alu_result[WIDTH-1] ^ alu_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      m     <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= {s, alu_result[WIDTH-1:1]};
          q    <= {alu_result[0], q[WIDTH-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign product_lo = q;
`ifdef MUL_HIGH_EN
  assign product_hi = acc;
`endif

endmodule

// File: doc/mul_booth_64.md
# mul_booth_64

Iterative signed 64×64 multiplier that initiates operations on an external `alu_64` instance, acting as the requester side of the ALU's `funct`/operand/flag interface. It uses radix-2 Booth recoding and issues one ALU `SUM` or `SUB` per cycle. Shifting and sequencing are done locally. It sits beside the execute-stage ALU and provides MUL support through a start/done handshake.

## Interface
Parameters:
- `WIDTH`, 64: operand width. It is fixed at 64 because it must match `alu_64`.

Ports:
- `clk`  in  1: clock. Everything is sampled on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply. Accepted only when `ready`=1.
- `a`  in  64: multiplicand, signed. Sampled at acceptance.
- `b`  in  64: multiplier, signed. Sampled at acceptance.
- `ready`  out  1: 1 in IDLE.
- `done`  out  1: one-cycle pulse when the product is valid.
- `product_lo`  out  64: low half of the signed 128-bit product.
- `product_hi`  out  64: high half. Present only with `MUL_HIGH_EN`.
- `alu_funct`  out  3: ALU operation. `SUM`=0, `SUB`=2.
- `alu_a`  out  64: ALU operand a.
- `alu_b`  out  64: ALU operand b.
- `alu_result`  in  64: ALU result. Combinational and used in the same cycle.
- `alu_overflow`  in  1: ALU signed-overflow flag. Used in the same cycle.

## Operation
Registers:
- `acc` (64): high partial product.
- `q` (64): low partial product / multiplier.
- `q_m1` (1): Booth history bit.
- `m` (64): multiplicand.
- `cnt` (6): iteration counter.

State machine `IDLE → RUN → DONE → IDLE`.
- **IDLE:** `ready`=1. On `start`=1: `m`←`a`, `q`←`b`, `acc`←0, `q_m1`←0, `cnt`←0, go to RUN.
- **RUN:** drive `alu_a`=`acc` every cycle. Select the ALU request from `{q[0], q_m1}`:
  - `01`: `alu_funct`=SUM, `alu_b`=`m`.
  - `10`: `alu_funct`=SUB, `alu_b`=`m`.
  - `00`/`11`: `alu_funct`=SUM, `alu_b`=0.
- **RUN update:** let `s` = `alu_result[63] ^ alu_overflow` (the true sign of the 65-bit sum).
  - Update `{acc,q,q_m1}` ← `{s, alu_result, q}` (arithmetic right shift by 1).
  - `cnt`←`cnt`+1. When `cnt`==63 this cycle, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Product outputs:** `product_lo`=`q`, `product_hi`=`acc`. Both are held stable from DONE until the next accepted `start`.
- **`start` outside IDLE:** ignored; it is not queued.
- **`a`/`b` after acceptance:** changes have no effect.
- **ALU outputs outside RUN:** `alu_funct`=SUM, `alu_a`=0, `alu_b`=0.
- **Overflow correction:** the `s` correction makes `m`=−2^63 correct. The result is exact for all operand pairs; the 128-bit product never overflows.
- **Reset:** from any state, including mid-RUN, return to IDLE and clear `acc`, `q`, `q_m1`, `m`, `cnt`.

Reset values of outputs:
- `ready`=1, `done`=0.
- `product_lo`=0, `product_hi`=0.
- `alu_funct`=0, `alu_a`=0, `alu_b`=0.

## Timing
- **Acceptance:** `start` is accepted at edge E0.
- **RUN:** occupies the 64 cycles after E0 (edges E1..E64).
- **DONE:** `done`=1 in the cycle after E64. Latency from acceptance to `done` is 65 cycles.
- **Back-to-back:** the next `start` is accepted at the edge ending the IDLE cycle that follows DONE. Minimum issue interval is 66 cycles.
- **Combinational path:** the path `acc`/`q` → ALU → `{acc,q}` is one combinational path through `alu_64` per cycle.

## Configuration
- `MUL_HIGH_EN` defined: the `product_hi` port exists and carries `acc`.
- `MUL_HIGH_EN` undefined: the `product_hi` port is absent. The `acc` register and its logic remain because they are needed for Booth. `product_lo` behaviour is identical in both cases.

## Structure
- **Shared package `alu_pkg`:** holds the `alu_funct_e` enum (SUM=0, SHIFT_LEFT=1, SUB=2, LOAD=3, XOR=4, SHIFT_RIGHT=5, NOT=6, AND=7) and `ALU_WIDTH`=64. `alu_64` and this block both import it.
- **Local typedef:** the state enum `mul_state_e` stays local.
- **Sub-modules:** none. `alu_64` is instantiated by the parent or bench and connected through the `alu_*` ports, so it can be shared with the datapath.

## Test plan
All scenarios connect a real `alu_64` and define `MUL_HIGH_EN`.
- `a`=12, `b`=25 → `done` 65 cycles after acceptance, `product_lo`=300, `product_hi`=0.
- `a`=−3, `b`=7 → `product_lo`=−21, `product_hi`=64'hFFFF_FFFF_FFFF_FFFF.
- `a`=`b`=64'h8000_0000_0000_0000 → `product_hi`=64'h4000_0000_0000_0000, `product_lo`=0. This exercises the overflow-sign correction.
- `start` pulsed with new operands during RUN → ignored; the original product is delivered and `done` pulses once.
- `reset` asserted at RUN iteration 10 → next cycle `ready`=1, `done`=0, products=0. A following 5×5 gives 25.
- Operations issued back-to-back, `start` held high → 66-cycle spacing. Products stay stable between each `done` and the next acceptance.
